// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - parallel-load / serial-out handshake bundle for bit_serializer
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             sout;
    logic             valid;
    logic             done;

    // word producer side
    modport master (
        output load,
        output data,
        input  ready,
        input  sout,
        input  valid,
        input  done
    );

    // serializer side
    modport slave (
        input  load,
        input  data,
        output ready,
        output sout,
        output valid,
        output done
    );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first parallel-to-serial converter; macro PARITY_EN appends an even-parity bit
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    bit_serializer_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    // Reject out-of-range widths at elaboration time
    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
            $error("bit_serializer: WIDTH must be in 2..16");
        end
    endgenerate

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             ready_int;
    logic             done_int;
    logic             sout_int;
    logic             valid_int;
    logic             accept;
`ifdef PARITY_EN
    logic             par_acc;
`endif

    // Output decode: everything here depends only on registered state,
    // so load/data never reach an output combinationally.
    always_comb begin
        last_bit  = 1'b0;
        done_int  = 1'b0;
        ready_int = 1'b0;
        sout_int  = 1'b0;
        valid_int = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
            end
            SHIFT: begin
                last_bit  = (cnt == LAST);
                sout_int  = sreg[WIDTH-1];
                valid_int = 1'b1;
`ifdef PARITY_EN
                // the parity bit, not the last data bit, closes the word
                done_int  = 1'b0;
                ready_int = 1'b0;
`else
                done_int  = last_bit;
                ready_int = last_bit;
`endif
            end
`ifdef PARITY_EN
            PAR: begin
                sout_int  = par_acc;
                valid_int = 1'b1;
                done_int  = 1'b1;
                ready_int = 1'b1;
            end
`endif
            default: begin
                ready_int = 1'b1;
            end
        endcase
    end

    assign accept    = bus.load & ready_int;
    assign bus.ready = ready_int;
    assign bus.sout  = sout_int;
    assign bus.valid = valid_int;
    assign bus.done  = done_int;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an accept on the closing cycle of a word restarts SHIFT with no gap
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PARITY_EN
                    next_state = PAR;
`else
                    next_state = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                next_state = accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift register and bit counter; counter holds at LAST so it never wraps inside a word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bus.data;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef PARITY_EN
    // Even-parity accumulator: folds in each data bit as it leaves on sout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_acc <= 1'b0;
        end else if (accept) begin
            par_acc <= 1'b0;
        end else if (state == SHIFT) begin
            par_acc <= par_acc ^ sreg[WIDTH-1];
        end
    end
`endif

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per word; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 load  input  1  request to accept a parallel word.
REQ-005 data  input  WIDTH  parallel word, sampled on the rising edge when load and ready are both high.
REQ-006 ready  output  1  serializer can accept a word this cycle.
REQ-007 sout  output  1  serial bit stream, MSB first; feeds the downstream sequence detector's x input.
REQ-008 valid  output  1  sout carries a data or parity bit this cycle.
REQ-009 done  output  1  high during the final serial bit of a word.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and, when PARITY_EN is defined, PAR.
- Encoding is implementation choice.
REQ-011 A word SHALL be accepted on the rising edge where load=1 and ready=1.
- On acceptance, data is captured into a WIDTH-bit shift register.
- The bit counter is cleared.
- The FSM goes to SHIFT.
REQ-012 In SHIFT, sout SHALL equal the shift-register MSB and valid SHALL be 1.
- Each rising edge shifts the register left by one and increments the counter.
REQ-013 The first data bit (data[WIDTH-1]) SHALL appear on sout in the cycle immediately after acceptance.
- Latency from accept edge to first bit: 1 cycle.
- Bit k (k = 0 for MSB) appears in cycle k+1 after acceptance.
REQ-014 The counter SHALL be ceil(log2(WIDTH+1)) bits wide.
- It counts 0..WIDTH-1 and never wraps within a word.
REQ-015 With PARITY_EN undefined, after bit WIDTH-1 the FSM SHALL go to IDLE, unless a new word is accepted on that same edge (REQ-018).
REQ-016 ready SHALL be 1 in IDLE and during the final serial bit of a word; it SHALL be 0 in all other cycles.
REQ-017 done SHALL be 1 only during the final serial bit of a word.
- Without parity: data bit WIDTH-1. With parity: the parity bit.
REQ-018 Back-to-back: load=1 during the final-bit cycle SHALL capture the new word on that edge.
- The new word's MSB follows the final bit with no gap.
- valid stays 1 across the boundary.
REQ-019 load=1 while ready=0 SHALL be ignored: no capture and no state change.
- data changes while busy SHALL NOT affect sout.
REQ-020 In IDLE, sout SHALL be 0, valid 0 and done 0.
REQ-021 All outputs SHALL be pure functions of registered state; no combinational path from load or data to any output.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for clk, force:
- FSM to IDLE;
- shift register, counter and parity accumulator to 0;
- sout=0, valid=0, done=0, ready=1.
REQ-023 Reset asserted mid-word SHALL abort the word; no remaining bits are emitted after release.
REQ-024 After reset deasserts, the first rising edge with load=1 SHALL be accepted normally.

Configuration
REQ-025 Macro PARITY_EN SHALL compile in an even-parity bit appended after the data bits.
REQ-026 With PARITY_EN defined:
- after bit WIDTH-1 the FSM SHALL enter PAR for exactly one cycle;
- in PAR, sout = XOR of all WIDTH captured bits and valid=1;
- it then goes to IDLE, or back to SHIFT if a word is accepted on the PAR edge.
- Word length: WIDTH+1 cycles.
REQ-027 With PARITY_EN undefined:
- no PAR state and no parity logic SHALL exist;
- word length: WIDTH cycles.

Verification
REQ-028 WIDTH=8, no parity, reset pulse then load 8'hA5 for one cycle:
- next 8 cycles sout = 1,0,1,0,0,1,0,1 with valid=1;
- done=1 and ready=1 only in cycle 8;
- then sout=0, valid=0.
REQ-029 load 8'hA0 then, in its final-bit cycle, load 8'h05:
- sout = 1,0,1,0,0,0,0,0,0,0,0,0,0,1,0,1 over 16 contiguous cycles with valid=1 throughout;
- this stream drives the downstream 101 detector.
REQ-030 Accept 8'hFF, then hold load=1 with data=8'h00 during cycles 2..7:
- sout = eight 1s;
- no capture until the cycle-8 edge.
REQ-031 Accept 8'hA5, assert reset asynchronously (between clk edges) during bit 3:
- sout=0, valid=0, ready=1 within the same cycle;
- no further bits after release.
REQ-032 PARITY_EN defined:
- 8'hA5 yields 9 bits ending in parity 0;
- 8'h07 yields 0,0,0,0,0,1,1,1 then parity 1;
- done=1 only on the parity bit.
